per2axi_res_unit: RTL and testbench

Response path of the peripheral-to-AXI bridge, generalised over AXI data width and per-ID outstanding depth. It converts AXI R and B beats into single-beat 32-bit peripheral responses. Word-lane selection comes from a per-ID FIFO of request address offsets. The block also adds fair R/B arbitration, a registered response stage, R-error forwarding, ATOP B-suppression and request backpressure when an ID's lane FIFO is full. It sits between the AXI master port and the peripheral interconnect response channel, alongside the bridge's request channel.

---
 rtl/per2axi_pkg.sv | 21 ++
 rtl/per2axi_res_unit_if.sv | 65 ++++++
 rtl/per2axi_lane_fifo.sv | 47 ++++
 rtl/per2axi_res_unit.sv | 164 ++++++++++++++++
 tb/tb_per2axi_res_unit.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/per2axi_pkg.sv
// Shared types and helpers for the per2axi response path.
// Holds the ATOP tracking states, the lane-width function and the B encoding.
package per2axi_pkg;

  typedef enum logic [1:0] {
    ATOP_NONE,
    ATOP_REQUEST,
    ATOP_WAIT_R,
    ATOP_WAIT_B
  } atop_res_t;

  function automatic int lane_w(input int dw);
    if (dw <= 64) return 1;
    return $clog2(dw / 32);
  endfunction

  function automatic logic [31:0] b_rdata(input logic [1:0] resp);
    return {30'b0, resp[1], ~(resp[1] ^ resp[0])};
  endfunction

endpackage

// File: rtl/per2axi_res_unit_if.sv
// Bundle of AXI R/B, request-side and peripheral response signals.
// The slave view belongs to the response unit; master is its environment.
interface per2axi_res_unit_if #(
  parameter int PER_ID_WIDTH   = 5,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 3,
  parameter int AXI_USER_WIDTH = 6
);
  logic                      per_slave_r_valid_o;
  logic                      per_slave_r_opc_o;
  logic [PER_ID_WIDTH-1:0]   per_slave_r_id_o;
  logic [31:0]               per_slave_r_rdata_o;

  logic                      axi_master_r_valid_i;
  logic [AXI_DATA_WIDTH-1:0] axi_master_r_data_i;
  logic [1:0]                axi_master_r_resp_i;
  logic                      axi_master_r_last_i;
  logic [AXI_ID_WIDTH-1:0]   axi_master_r_id_i;
  logic [AXI_USER_WIDTH-1:0] axi_master_r_user_i;
  logic                      axi_master_r_ready_o;

  logic                      axi_master_b_valid_i;
  logic [1:0]                axi_master_b_resp_i;
  logic [AXI_ID_WIDTH-1:0]   axi_master_b_id_i;
  logic [AXI_USER_WIDTH-1:0] axi_master_b_user_i;
  logic                      axi_master_b_ready_o;

  logic                      trans_req_i;
  logic [AXI_ID_WIDTH-1:0]   trans_id_i;
  logic [AXI_ADDR_WIDTH-1:0] trans_add_i;
  logic                      trans_ready_o;
  logic                      atop_req_i;
  logic [AXI_ID_WIDTH-1:0]   atop_id_i;

  modport slave (
    output per_slave_r_valid_o, per_slave_r_opc_o,
    output per_slave_r_id_o, per_slave_r_rdata_o,
    input  axi_master_r_valid_i, axi_master_r_data_i,
    input  axi_master_r_resp_i, axi_master_r_last_i,
    input  axi_master_r_id_i, axi_master_r_user_i,
    output axi_master_r_ready_o,
    input  axi_master_b_valid_i, axi_master_b_resp_i,
    input  axi_master_b_id_i, axi_master_b_user_i,
    output axi_master_b_ready_o,
    input  trans_req_i, trans_id_i, trans_add_i,
    output trans_ready_o,
    input  atop_req_i, atop_id_i
  );

  modport master (
    input  per_slave_r_valid_o, per_slave_r_opc_o,
    input  per_slave_r_id_o, per_slave_r_rdata_o,
    output axi_master_r_valid_i, axi_master_r_data_i,
    output axi_master_r_resp_i, axi_master_r_last_i,
    output axi_master_r_id_i, axi_master_r_user_i,
    input  axi_master_r_ready_o,
    output axi_master_b_valid_i, axi_master_b_resp_i,
    output axi_master_b_id_i, axi_master_b_user_i,
    input  axi_master_b_ready_o,
    output trans_req_i, trans_id_i, trans_add_i,
    input  trans_ready_o,
    output atop_req_i, atop_id_i
  );
endinterface

// File: rtl/per2axi_lane_fifo.sv
// Small per-ID FIFO of word-lane offsets for outstanding reads.
// Pop on empty is ignored; push while full is accepted only with a pop.
module per2axi_lane_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == (PW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_head  = r_mem[r_rptr];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + (PW+1)'(1);
      else if (w_pop && !w_push) r_cnt <= r_cnt - (PW+1)'(1);
    end
  end
endmodule

// File: rtl/per2axi_res_unit.sv
// AXI R/B to single-beat peripheral response converter with fair
// arbitration, per-ID lane FIFOs and ATOP B-suppression.
module per2axi_res_unit
  import per2axi_pkg::*;
#(
  parameter int PER_ID_WIDTH   = 5,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 3,
  parameter int AXI_USER_WIDTH = 6,
  parameter int MAX_OUTST      = 4
) (
  input logic clk_i,
  input logic rst_ni,
  per2axi_res_unit_if.slave bus
);
  localparam int LW = lane_w(AXI_DATA_WIDTH);
  localparam int NL = AXI_DATA_WIDTH / 32;
  localparam int IW = AXI_ID_WIDTH;
  localparam int PN = PER_ID_WIDTH;

  logic          w_gnt_r;
  logic          w_gnt_b;
  logic          r_last_b;
  logic          w_trans_ready;
  logic [IW-1:0] w_rid;
  logic [IW-1:0] w_bid;
  logic [PN-1:0] w_push;
  logic [PN-1:0] w_pop;
  logic [PN-1:0] w_full;
  logic [PN-1:0] w_empty;
  logic [LW-1:0] w_head [PN];
  logic [LW-1:0] w_lane_in;
  logic [LW-1:0] w_r_lane;
  logic          w_r_empty;

  atop_res_t     r_atop [PN];
  atop_res_t     w_atop_nxt [PN];
  logic          r_atop_err;
  logic          w_atop_err;

  logic          r_valid, w_valid;
  logic          r_opc, w_opc;
  logic [PN-1:0] r_id, w_id;
  logic [31:0]   r_rdata, w_rdata;
  logic          w_unused;

  assign w_rid     = bus.axi_master_r_id_i;
  assign w_bid     = bus.axi_master_b_id_i;
  assign w_lane_in = bus.trans_add_i[LW+1:2];
  assign w_unused  = ^{bus.axi_master_r_user_i,
                       bus.axi_master_b_user_i,
                       bus.trans_add_i};

  // R wins a tie only when B was granted last
  assign w_gnt_r = bus.axi_master_r_valid_i &&
                   (!bus.axi_master_b_valid_i || r_last_b);
  assign w_gnt_b = bus.axi_master_b_valid_i && !w_gnt_r;

  assign bus.axi_master_r_ready_o = w_gnt_r;
  assign bus.axi_master_b_ready_o = w_gnt_b;

  assign w_trans_ready = !w_full[bus.trans_id_i] ||
                         w_pop[bus.trans_id_i];
  assign bus.trans_ready_o = w_trans_ready;

  for (genvar g = 0; g < PN; g++) begin : g_fifo
    assign w_push[g] = bus.trans_req_i && w_trans_ready &&
                       (bus.trans_id_i == IW'(g));
    assign w_pop[g]  = w_gnt_r && bus.axi_master_r_last_i &&
                       (w_rid == IW'(g));
    per2axi_lane_fifo #(
      .DEPTH (MAX_OUTST),
      .W     (LW)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .i_push  (w_push[g]),
      .i_pop   (w_pop[g]),
      .i_data  (w_lane_in),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g]),
      .o_head  (w_head[g])
    );
  end

  always_comb begin
    w_valid   = 1'b0;
    w_opc     = 1'b0;
    w_id      = '0;
    w_rdata   = '0;
    w_r_empty = w_empty[w_rid];
    w_r_lane  = '0;
    if (w_gnt_r) begin
      w_r_lane = w_r_empty ? '0 : w_head[w_rid];
      w_valid  = 1'b1;
      w_id     = PN'(1) << w_rid;
      w_opc    = bus.axi_master_r_resp_i[1] || w_r_empty;
      for (int k = 0; k < NL; k++) begin
        if (int'(w_r_lane) == k)
          w_rdata = bus.axi_master_r_data_i[32*k +: 32];
      end
    end else if (w_gnt_b && r_atop[w_bid] == ATOP_NONE) begin
      w_valid = 1'b1;
      w_id    = PN'(1) << w_bid;
      w_opc   = bus.axi_master_b_resp_i[1];
      w_rdata = b_rdata(bus.axi_master_b_resp_i);
    end
  end

  always_comb begin
    w_atop_err = bus.atop_req_i &&
                 (r_atop[bus.atop_id_i] != ATOP_NONE);
    for (int i = 0; i < PN; i++) begin
      w_atop_nxt[i] = r_atop[i];
      unique case (r_atop[i])
        ATOP_NONE:
          if (bus.atop_req_i && bus.atop_id_i == IW'(i))
            w_atop_nxt[i] = ATOP_REQUEST;
        ATOP_REQUEST:
          if (w_gnt_r && w_rid == IW'(i))
            w_atop_nxt[i] = ATOP_WAIT_B;
          else if (w_gnt_b && w_bid == IW'(i))
            w_atop_nxt[i] = ATOP_WAIT_R;
        ATOP_WAIT_R:
          if (w_gnt_r && w_rid == IW'(i))
            w_atop_nxt[i] = ATOP_NONE;
        ATOP_WAIT_B:
          if (w_gnt_b && w_bid == IW'(i))
            w_atop_nxt[i] = ATOP_NONE;
        default: w_atop_nxt[i] = ATOP_NONE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_last_b   <= 1'b1;
      r_atop_err <= 1'b0;
      r_valid    <= 1'b0;
      r_opc      <= 1'b0;
      r_id       <= '0;
      r_rdata    <= '0;
      for (int i = 0; i < PN; i++) r_atop[i] <= ATOP_NONE;
    end else begin
      if (w_gnt_r)      r_last_b <= 1'b0;
      else if (w_gnt_b) r_last_b <= 1'b1;
      if (w_atop_err)   r_atop_err <= 1'b1;
      r_valid <= w_valid;
      r_opc   <= w_opc;
      r_id    <= w_id;
      r_rdata <= w_rdata;
      for (int i = 0; i < PN; i++) r_atop[i] <= w_atop_nxt[i];
    end
  end

  assign bus.per_slave_r_valid_o = r_valid;
  assign bus.per_slave_r_opc_o   = r_opc;
  assign bus.per_slave_r_id_o    = r_id;
  assign bus.per_slave_r_rdata_o = r_rdata;

  a_atop_reissue: assert property (
    @(posedge clk_i) disable iff (!rst_ni) !r_atop_err);
endmodule

// File: tb/tb_per2axi_res_unit.sv
// Scoreboard bench for per2axi_res_unit with a queue-based reference model.
// Directed scenarios followed by a randomized phase and a mid-run reset.
module tb_per2axi_res_unit;
  localparam int PIW = 5;
  localparam int AW  = 32;
  localparam int DW  = 128;
  localparam int IW  = 3;
  localparam int UW  = 6;
  localparam int MO  = 4;
  localparam int NL  = DW / 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  per2axi_res_unit_if #(
    .PER_ID_WIDTH(PIW), .AXI_ADDR_WIDTH(AW),
    .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW),
    .AXI_USER_WIDTH(UW)
  ) bus_if ();

  per2axi_res_unit #(
    .PER_ID_WIDTH(PIW), .AXI_ADDR_WIDTH(AW),
    .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW),
    .AXI_USER_WIDTH(UW), .MAX_OUTST(MO)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus_if)
  );

  typedef struct {
    bit        opc;
    bit [4:0]  id;
    bit [31:0] rdata;
    int        due;
  } exp_t;

  exp_t sb[$];
  int   lanes [PIW][$];
  bit   b_owed [PIW];
  bit   r_owed [PIW];
  bit   prefer_r = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // monitor: every output pulse must match the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus_if.per_slave_r_valid_o) begin
          if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_pulse: got rdata %0h expected none",
                     bus_if.per_slave_r_rdata_o);
          end else begin
            e = sb.pop_front();
            chk("latency", cyc, e.due);
            chk("opc", bus_if.per_slave_r_opc_o, e.opc);
            chk("id", bus_if.per_slave_r_id_o, e.id);
            chk("rdata", bus_if.per_slave_r_rdata_o, e.rdata);
          end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
          n_chk++; n_fail++;
          $display("FAIL missing_pulse: got none expected rdata %0h",
                   sb[0].rdata);
          void'(sb.pop_front());
        end
      end
    end
  end

  function automatic bit [31:0] b_code(bit [1:0] r);
    case (r)
      2'b00:   return 32'd1;
      2'b01:   return 32'd0;
      2'b10:   return 32'd2;
      default: return 32'd3;
    endcase
  endfunction

  task automatic idle();
    bus_if.axi_master_r_valid_i = 1'b0;
    bus_if.axi_master_b_valid_i = 1'b0;
    bus_if.trans_req_i = 1'b0;
    bus_if.atop_req_i  = 1'b0;
  endtask

  task automatic drive_r(int id, bit last, bit [1:0] resp,
                         bit [DW-1:0] d);
    bus_if.axi_master_r_valid_i = 1'b1;
    bus_if.axi_master_r_id_i    = IW'(id);
    bus_if.axi_master_r_last_i  = last;
    bus_if.axi_master_r_resp_i  = resp;
    bus_if.axi_master_r_data_i  = d;
    bus_if.axi_master_r_user_i  = UW'($urandom);
  endtask

  task automatic drive_b(int id, bit [1:0] resp);
    bus_if.axi_master_b_valid_i = 1'b1;
    bus_if.axi_master_b_id_i    = IW'(id);
    bus_if.axi_master_b_resp_i  = resp;
    bus_if.axi_master_b_user_i  = UW'($urandom);
  endtask

  task automatic drive_t(int id, bit [31:0] a, bit atop);
    bus_if.trans_req_i = 1'b1;
    bus_if.trans_id_i  = IW'(id);
    bus_if.trans_add_i = a;
    bus_if.atop_req_i  = atop;
    bus_if.atop_id_i   = IW'(id);
  endtask

  function automatic bit [DW-1:0] rnd_data();
    bit [DW-1:0] d;
    for (int i = 0; i < NL; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  // one cycle: check readies against the model, then advance the model
  task automatic step();
    bit gr, gb, tr, pop_same, atop_free;
    int rid, bid, tid, aid, lane;
    exp_t e;
    @(negedge clk);
    rid = int'(bus_if.axi_master_r_id_i);
    bid = int'(bus_if.axi_master_b_id_i);
    tid = int'(bus_if.trans_id_i);
    aid = int'(bus_if.atop_id_i);
    gr = bus_if.axi_master_r_valid_i &&
         (!bus_if.axi_master_b_valid_i || prefer_r);
    gb = bus_if.axi_master_b_valid_i && !gr;
    chk("r_ready", bus_if.axi_master_r_ready_o, gr);
    chk("b_ready", bus_if.axi_master_b_ready_o, gb);
    pop_same = gr && bus_if.axi_master_r_last_i && rid == tid;
    tr = lanes[tid].size() < MO || pop_same;
    chk("trans_ready", bus_if.trans_ready_o, tr);
    atop_free = !b_owed[aid] && !r_owed[aid];
    if (gr) begin
      prefer_r = 1'b0;
      lane = lanes[rid].size() > 0 ? lanes[rid][0] : 0;
      e.opc = bus_if.axi_master_r_resp_i[1] || lanes[rid].size() == 0;
      e.rdata = 32'(bus_if.axi_master_r_data_i >> (32 * lane));
      e.id = 5'(1 << rid);
      e.due = cyc + 1;
      sb.push_back(e);
      if (bus_if.axi_master_r_last_i && lanes[rid].size() > 0)
        void'(lanes[rid].pop_front());
      r_owed[rid] = 1'b0;
    end
    if (gb) begin
      prefer_r = 1'b1;
      if (!b_owed[bid] && !r_owed[bid]) begin
        e.opc = bus_if.axi_master_b_resp_i[1];
        e.rdata = b_code(bus_if.axi_master_b_resp_i);
        e.id = 5'(1 << bid);
        e.due = cyc + 1;
        sb.push_back(e);
      end
      b_owed[bid] = 1'b0;
    end
    if (bus_if.trans_req_i && tr)
      lanes[tid].push_back(int'((bus_if.trans_add_i >> 2) % NL));
    if (bus_if.atop_req_i && atop_free) begin
      b_owed[aid] = 1'b1;
      r_owed[aid] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit [DW-1:0] d;
    idle();
    bus_if.axi_master_r_id_i = '0;
    bus_if.axi_master_r_data_i = '0;
    bus_if.axi_master_r_resp_i = '0;
    bus_if.axi_master_r_last_i = 1'b0;
    bus_if.axi_master_r_user_i = '0;
    bus_if.axi_master_b_id_i = '0;
    bus_if.axi_master_b_resp_i = '0;
    bus_if.axi_master_b_user_i = '0;
    bus_if.trans_id_i = '0;
    bus_if.trans_add_i = '0;
    bus_if.atop_id_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", bus_if.per_slave_r_valid_o, 0);
    chk("rst_opc", bus_if.per_slave_r_opc_o, 0);
    chk("rst_id", bus_if.per_slave_r_id_o, 0);
    chk("rst_rdata", bus_if.per_slave_r_rdata_o, 0);
    chk("rst_trans_ready", bus_if.trans_ready_o, 1);
    chk("rst_r_ready", bus_if.axi_master_r_ready_o, 0);
    chk("rst_b_ready", bus_if.axi_master_b_ready_o, 0);
    rst_n = 1'b1;

    // read id2 at lane 3 of a 128-bit beat
    drive_t(2, 32'h1000_000C, 1'b0);
    step(); idle();
    d = rnd_data();
    d[127:96] = 32'hDEADBEEF;
    drive_r(2, 1'b1, 2'b00, d);
    step(); idle();
    chk("lane3_rdata", bus_if.per_slave_r_rdata_o, 32'hDEADBEEF);
    chk("lane3_id", bus_if.per_slave_r_id_o, 32'b00100);
    step();

    // fill id1, stall, then pop and push together
    for (int i = 0; i < MO; i++) begin
      drive_t(1, 32'(i * 4), 1'b0);
      step();
    end
    drive_t(1, 32'h8, 1'b0);
    step();
    chk("full_stall", bus_if.trans_ready_o, 0);
    drive_r(1, 1'b1, 2'b00, rnd_data());
    step(); idle();
    for (int i = 0; i < MO; i++) begin
      drive_r(1, 1'b1, 2'b00, rnd_data());
      step();
    end
    idle(); step();

    // plain store responses on id4
    drive_b(4, 2'b10); step();
    drive_b(4, 2'b00); step(); idle(); step();

    // R and B contending for four cycles
    drive_r(0, 1'b1, 2'b00, rnd_data());
    drive_b(1, 2'b00);
    for (int i = 0; i < 4; i++) begin
      step();
      bus_if.axi_master_r_data_i = rnd_data();
      bus_if.axi_master_b_resp_i = 2'($urandom);
    end
    idle(); step();

    // ATOP on id3: B first is swallowed, R is forwarded
    drive_t(3, 32'h4, 1'b1);
    step(); idle();
    drive_b(3, 2'b00); step(); idle(); step();
    drive_r(3, 1'b1, 2'b00, rnd_data()); step(); idle();
    drive_b(3, 2'b01); step(); idle(); step();

    for (int n = 0; n < 400; n++) begin
      int t;
      idle();
      if ($urandom_range(0, 1) == 1)
        drive_r($urandom_range(0, PIW - 1), $urandom_range(0, 3) != 0,
                2'($urandom), rnd_data());
      if ($urandom_range(0, 1) == 1)
        drive_b($urandom_range(0, PIW - 1), 2'($urandom));
      t = $urandom_range(0, PIW - 1);
      drive_t(t, $urandom, 1'b0);
      bus_if.trans_req_i = ($urandom_range(0, 2) != 0);
      if (bus_if.trans_req_i && !b_owed[t] && !r_owed[t] &&
          $urandom_range(0, 7) == 0)
        bus_if.atop_req_i = 1'b1;
      step();
    end
    idle(); step(); step();

    // reset with a response in flight
    drive_r(0, 1'b0, 2'b00, rnd_data());
    drive_t(2, 32'h0, 1'b0);
    step(); idle();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus_if.per_slave_r_valid_o, 0);
    chk("mid_rst_rdata", bus_if.per_slave_r_rdata_o, 0);
    chk("mid_rst_trans_ready", bus_if.trans_ready_o, 1);
    sb.delete();
    for (int i = 0; i < PIW; i++) begin
      lanes[i].delete();
      b_owed[i] = 1'b0;
      r_owed[i] = 1'b0;
    end
    prefer_r = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_r(2, 1'b1, 2'b00, rnd_data());
    step(); idle();
    chk("post_rst_empty_opc", bus_if.per_slave_r_opc_o, 1);
    step(); step();
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
